// File: rtl/vliw_keep_buffer.sv
// Keep buffer for the VLIW pipeline: snapshots the slot-1/2 M-stage and slot-3/4
// W-stage results when a multi-cycle FPU stall begins, so the frozen execute
// bundle can still forward from them once it re-issues.
module vliw_keep_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              Read_data_keep,
    input  logic              StallE,
    input  logic [REG_W-1:0]  writeRegM1,
    input  logic [REG_W-1:0]  writeRegM2,
    input  logic              RegWriteM1,
    input  logic              RegWriteM2,
    input  logic [DATA_W-1:0] ResultM1,
    input  logic [DATA_W-1:0] ResultM2,
    input  logic [REG_W-1:0]  writeRegW3,
    input  logic [REG_W-1:0]  writeRegW4,
    input  logic              RegWriteW3,
    input  logic              RegWriteW4,
    input  logic [DATA_W-1:0] ResultW3,
    input  logic [DATA_W-1:0] ResultW4,
    output logic [REG_W-1:0]  writeRegKept1,
    output logic [REG_W-1:0]  writeRegKept2,
    output logic [REG_W-1:0]  writeRegKept3,
    output logic [REG_W-1:0]  writeRegKept4,
    output logic              RegWriteKept1,
    output logic              RegWriteKept2,
    output logic              RegWriteKept3,
    output logic              RegWriteKept4,
    output logic [DATA_W-1:0] ResultKept1,
    output logic [DATA_W-1:0] ResultKept2,
    output logic [DATA_W-1:0] ResultKept3,
    output logic [DATA_W-1:0] ResultKept4,
    output logic              fstalled
);

    typedef enum logic [1:0] {StIdle, StHold, StRelease} state_t;

    state_t            state;
    logic [REG_W-1:0]  reg_in   [4];
    logic              we_in    [4];
    logic [DATA_W-1:0] res_in   [4];
    logic [REG_W-1:0]  kept_reg [4];
    logic              kept_we  [4];
    logic [DATA_W-1:0] kept_res [4];
    logic              capture;

    // Gather the four slots into arrays so capture/clear is one loop.
    assign reg_in[0] = writeRegM1;
    assign reg_in[1] = writeRegM2;
    assign reg_in[2] = writeRegW3;
    assign reg_in[3] = writeRegW4;
    assign we_in[0]  = RegWriteM1;
    assign we_in[1]  = RegWriteM2;
    assign we_in[2]  = RegWriteW3;
    assign we_in[3]  = RegWriteW4;
    assign res_in[0] = ResultM1;
    assign res_in[1] = ResultM2;
    assign res_in[2] = ResultW3;
    assign res_in[3] = ResultW4;

    // A strobe during HOLD is ignored; in RELEASE it wins over clearing.
    assign capture = Read_data_keep && (state != StHold);

    // FSM with registered kept entries and fstalled flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= StIdle;
            fstalled <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                kept_reg[i] <= '0;
                kept_we[i]  <= 1'b0;
                kept_res[i] <= '0;
            end
        end else if (capture) begin
            state    <= StHold;
            fstalled <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                kept_reg[i] <= reg_in[i];
                // Register 0 is hardwired; never forward a write to it.
                kept_we[i]  <= we_in[i] && (reg_in[i] != '0);
                kept_res[i] <= res_in[i];
            end
        end else begin
            case (state)
                StHold: begin
                    // Keep contents one more cycle so the re-issued bundle forwards.
                    if (!StallE) begin
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    state    <= StIdle;
                    fstalled <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        kept_reg[i] <= '0;
                        kept_we[i]  <= 1'b0;
                        kept_res[i] <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Drive the flat output ports from the kept arrays.
    assign writeRegKept1 = kept_reg[0];
    assign writeRegKept2 = kept_reg[1];
    assign writeRegKept3 = kept_reg[2];
    assign writeRegKept4 = kept_reg[3];
    assign RegWriteKept1 = kept_we[0];
    assign RegWriteKept2 = kept_we[1];
    assign RegWriteKept3 = kept_we[2];
    assign RegWriteKept4 = kept_we[3];
    assign ResultKept1   = kept_res[0];
    assign ResultKept2   = kept_res[1];
    assign ResultKept3   = kept_res[2];
    assign ResultKept4   = kept_res[3];

endmodule

// File: tb/tb_vliw_keep_buffer.sv
// Scoreboard bench for vliw_keep_buffer: the driver queues the expected output
// snapshot for each clock edge, the monitor pops and compares on the negedge.
module tb_vliw_keep_buffer;

    typedef struct packed {
        logic [3:0]       we;
        logic [3:0][5:0]  rg;
        logic [3:0][31:0] res;
        logic             fst;
    } out_t;

    typedef struct {
        string name;
        out_t  v;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        Read_data_keep;
    logic        StallE;
    logic [5:0]  writeRegM1, writeRegM2, writeRegW3, writeRegW4;
    logic        RegWriteM1, RegWriteM2, RegWriteW3, RegWriteW4;
    logic [31:0] ResultM1, ResultM2, ResultW3, ResultW4;
    logic [5:0]  writeRegKept1, writeRegKept2, writeRegKept3, writeRegKept4;
    logic        RegWriteKept1, RegWriteKept2, RegWriteKept3, RegWriteKept4;
    logic [31:0] ResultKept1, ResultKept2, ResultKept3, ResultKept4;
    logic        fstalled;

    exp_t exp_q[$];
    exp_t mon_e;
    out_t act;
    int   n_checks = 0;
    int   n_fail   = 0;

    vliw_keep_buffer dut (
        .clk            (clk),
        .rstn           (rstn),
        .Read_data_keep (Read_data_keep),
        .StallE         (StallE),
        .writeRegM1     (writeRegM1),
        .writeRegM2     (writeRegM2),
        .RegWriteM1     (RegWriteM1),
        .RegWriteM2     (RegWriteM2),
        .ResultM1       (ResultM1),
        .ResultM2       (ResultM2),
        .writeRegW3     (writeRegW3),
        .writeRegW4     (writeRegW4),
        .RegWriteW3     (RegWriteW3),
        .RegWriteW4     (RegWriteW4),
        .ResultW3       (ResultW3),
        .ResultW4       (ResultW4),
        .writeRegKept1  (writeRegKept1),
        .writeRegKept2  (writeRegKept2),
        .writeRegKept3  (writeRegKept3),
        .writeRegKept4  (writeRegKept4),
        .RegWriteKept1  (RegWriteKept1),
        .RegWriteKept2  (RegWriteKept2),
        .RegWriteKept3  (RegWriteKept3),
        .RegWriteKept4  (RegWriteKept4),
        .ResultKept1    (ResultKept1),
        .ResultKept2    (ResultKept2),
        .ResultKept3    (ResultKept3),
        .ResultKept4    (ResultKept4),
        .fstalled       (fstalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected snapshot is consumed per negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            act.we  = {RegWriteKept4, RegWriteKept3, RegWriteKept2, RegWriteKept1};
            act.rg  = {writeRegKept4, writeRegKept3, writeRegKept2, writeRegKept1};
            act.res = {ResultKept4, ResultKept3, ResultKept2, ResultKept1};
            act.fst = fstalled;
            n_checks++;
            if (act !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s: actual we=%b reg=%h res=%h fst=%b, required we=%b reg=%h res=%h fst=%b",
                         mon_e.name, act.we, act.rg, act.res, act.fst,
                         mon_e.v.we, mon_e.v.rg, mon_e.v.res, mon_e.v.fst);
            end
        end
    end

    function automatic out_t mk(input logic [3:0] we,
                                input logic [5:0] r1, input logic [5:0] r2,
                                input logic [5:0] r3, input logic [5:0] r4,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [31:0] d4,
                                input logic f);
        out_t o;
        o.we     = we;
        o.rg[0]  = r1;
        o.rg[1]  = r2;
        o.rg[2]  = r3;
        o.rg[3]  = r4;
        o.res[0] = d1;
        o.res[1] = d2;
        o.res[2] = d3;
        o.res[3] = d4;
        o.fst    = f;
        return o;
    endfunction

    // we bit order: [0]=M1, [1]=M2, [2]=W3, [3]=W4
    task automatic drv(input logic [3:0] we,
                       input logic [5:0] r1, input logic [5:0] r2,
                       input logic [5:0] r3, input logic [5:0] r4,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [31:0] d4);
        RegWriteM1 = we[0];
        RegWriteM2 = we[1];
        RegWriteW3 = we[2];
        RegWriteW4 = we[3];
        writeRegM1 = r1;
        writeRegM2 = r2;
        writeRegW3 = r3;
        writeRegW4 = r4;
        ResultM1   = d1;
        ResultM2   = d2;
        ResultW3   = d3;
        ResultW4   = d4;
    endtask

    // Queue the expected result of the coming posedge, then advance one cycle.
    task automatic step(input string name, input out_t v);
        exp_t e;
        e.name = name;
        e.v    = v;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    out_t z, cap_a, cap_b, cap_c, cap_d, cap_e;
    int   guard;

    initial begin
        z     = mk(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        cap_a = mk(4'b1001, 6'd5, 6'd3, 6'd9, 6'd40,
                   32'h3F800000, 32'h11111111, 32'h22222222, 32'h12345678, 1'b1);
        cap_b = mk(4'b1011, 6'd1, 6'd63, 6'd0, 6'd2,
                   32'h0000000A, 32'h0000000B, 32'h55555555, 32'h0000000C, 1'b1);
        cap_c = mk(4'b0110, 6'd4, 6'd7, 6'd10, 6'd0,
                   32'h0D0D0D0D, 32'hAAAA5555, 32'h0E0E0E0E, 32'h0F0F0F0F, 1'b1);
        cap_d = mk(4'b0001, 6'd8, 6'd0, 6'd0, 6'd0, 32'h87654321, 32'h0, 32'h0, 32'h0, 1'b1);
        cap_e = mk(4'b0100, 6'd0, 6'd0, 6'd17, 6'd0, 32'h0, 32'h0, 32'h13579BDF, 32'h0, 1'b1);

        rstn = 1'b0;
        Read_data_keep = 1'b0;
        StallE = 1'b0;
        drv(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        #1;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            Read_data_keep = 1'($urandom);
            StallE         = 1'($urandom);
            drv(4'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                $urandom, $urandom, $urandom, $urandom);
            step("reset", z);
        end
        rstn = 1'b1;
        Read_data_keep = 1'b0;
        StallE = 1'b0;
        drv(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step("idle", z);

        // Basic capture, frozen HOLD, ignored strobe, release timing
        drv(4'b1001, 6'd5, 6'd3, 6'd9, 6'd40,
            32'h3F800000, 32'h11111111, 32'h22222222, 32'h12345678);
        Read_data_keep = 1'b1;
        StallE = 1'b1;
        step("capture", cap_a);
        Read_data_keep = 1'b0;
        drv(4'b1111, 6'd11, 6'd12, 6'd13, 6'd14,
            32'hDEADBEEF, 32'hCAFEF00D, 32'h01020304, 32'h0BADC0DE);
        step("hold_frozen1", cap_a);
        drv(4'b0110, 6'd20, 6'd21, 6'd22, 6'd23,
            32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666);
        step("hold_frozen2", cap_a);
        Read_data_keep = 1'b1;
        drv(4'b1111, 6'd30, 6'd31, 6'd32, 6'd33,
            32'h000000A1, 32'h000000A2, 32'h000000A3, 32'h000000A4);
        step("hold_ignore_strobe", cap_a);
        Read_data_keep = 1'b0;
        StallE = 1'b0;
        step("release_kept", cap_a);
        step("release_clear", z);
        step("idle_after", z);

        // Register zero is never kept
        drv(4'b1111, 6'd1, 6'd63, 6'd0, 6'd2,
            32'h0000000A, 32'h0000000B, 32'h55555555, 32'h0000000C);
        Read_data_keep = 1'b1;
        StallE = 1'b1;
        step("regzero_capture", cap_b);
        Read_data_keep = 1'b0;
        StallE = 1'b0;
        step("regzero_release", cap_b);

        // Re-stall in RELEASE: recapture, fstalled stays high
        drv(4'b1110, 6'd4, 6'd7, 6'd10, 6'd0,
            32'h0D0D0D0D, 32'hAAAA5555, 32'h0E0E0E0E, 32'h0F0F0F0F);
        Read_data_keep = 1'b1;
        StallE = 1'b1;
        step("restall_capture", cap_c);
        Read_data_keep = 1'b0;
        drv(4'b1111, 6'd1, 6'd1, 6'd1, 6'd1, 32'h1, 32'h1, 32'h1, 32'h1);
        step("restall_hold", cap_c);
        StallE = 1'b0;
        step("restall_release", cap_c);
        step("restall_clear", z);

        // Reset mid-HOLD
        drv(4'b0001, 6'd8, 6'd0, 6'd0, 6'd0, 32'h87654321, 32'h0, 32'h0, 32'h0);
        Read_data_keep = 1'b1;
        StallE = 1'b1;
        step("midhold_capture", cap_d);
        Read_data_keep = 1'b0;
        step("midhold_hold", cap_d);
        rstn = 1'b0;
        step("midhold_reset", z);
        rstn = 1'b1;
        StallE = 1'b0;
        step("post_reset_nostall", z);
        step("post_reset_idle", z);

        // Strobe without StallE in IDLE: capture, then straight to RELEASE
        drv(4'b0100, 6'd0, 6'd0, 6'd17, 6'd0, 32'h0, 32'h0, 32'h13579BDF, 32'h0);
        Read_data_keep = 1'b1;
        StallE = 1'b0;
        step("illegal_capture", cap_e);
        Read_data_keep = 1'b0;
        step("illegal_release", cap_e);
        step("illegal_clear", z);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vliw_keep_buffer.md
Name: vliw_keep_buffer

Overview:
- Holds the slot-1/2 memory-stage results and slot-3/4 writeback-stage results that are in flight when a multi-cycle FPU stall (fdiv, fsqrt) begins.
- Without this buffer those results would leave the forwarding window while the execute bundle is frozen.
- Feeds the hazard unit's Kept forwarding inputs (writeRegKept1-4, RegWriteKept1-4) and the execute-stage forwarding muxes (ResultKept1-4).
- Sits beside the M/W pipeline registers, downstream of the hazard unit's Read_data_keep / StallE outputs.

Parameters:
DATA_W, 32, width of each kept result
REG_W, 6, register-specifier width (64 int+float registers)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
Read_data_keep  in  1  capture strobe from hazard unit (first cycle of FPU stall)
StallE  in  1  execute stage frozen (FPU stall in progress)
writeRegM1  in  REG_W  slot-1 destination in M
writeRegM2  in  REG_W  slot-2 destination in M
RegWriteM1  in  1  slot-1 write enable in M
RegWriteM2  in  1  slot-2 write enable in M
ResultM1  in  DATA_W  slot-1 ALU/FPU result in M
ResultM2  in  DATA_W  slot-2 ALU/FPU result in M
writeRegW3  in  REG_W  slot-3 destination in W
writeRegW4  in  REG_W  slot-4 destination in W
RegWriteW3  in  1  slot-3 write enable in W
RegWriteW4  in  1  slot-4 write enable in W
ResultW3  in  DATA_W  slot-3 load/store-unit result in W
ResultW4  in  DATA_W  slot-4 load/store-unit result in W
writeRegKept1..4  out  REG_W  kept destinations
RegWriteKept1..4  out  1  kept write enables
ResultKept1..4  out  DATA_W  kept results
fstalled  out  1  kept entries valid for forwarding

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; all outputs 0.
- Reset in any state returns to IDLE and clears all outputs in the same edge. This includes mid-HOLD or RELEASE.
- States: IDLE, HOLD, RELEASE.
- IDLE -> HOLD when Read_data_keep=1 at posedge:
  - Latch all four slots: Kept1<=M1, Kept2<=M2, Kept3<=W3, Kept4<=W4.
  - For each slot, RegWriteKeptN <= RegWrite && (writeReg != 0). Register 0 is never kept.
  - fstalled <= 1 on the same edge, so outputs are valid the cycle after the strobe.
- IDLE with Read_data_keep=0: outputs unchanged (all 0). fstalled stays 0.
- HOLD:
  - Contents frozen regardless of M/W inputs.
  - Read_data_keep=1 in HOLD (back-to-back strobe) is ignored; no recapture.
  - Remains in HOLD while StallE=1.
  - StallE=0 -> RELEASE. Contents and fstalled=1 are kept for that cycle, so the re-issued execute bundle forwards from Kept.
- RELEASE -> IDLE on the next posedge:
  - All RegWriteKeptN <= 0 and fstalled <= 0.
  - writeRegKeptN and ResultKeptN <= 0.
- RELEASE with Read_data_keep=1 (new FPU stall immediately follows):
  - Recapture from current M/W inputs and go to HOLD. fstalled stays 1.
  - Capture takes priority over clearing.
- Read_data_keep=1 with StallE=0 in IDLE (illegal by construction):
  - Capture anyway and go to HOLD; the next cycle sees StallE=0 -> RELEASE.
- Latency: capture-to-output 1 cycle. Stall end to fstalled=0 is exactly 2 cycles after StallE falls (HOLD->RELEASE, RELEASE->IDLE).
- No combinational path from inputs to outputs; all outputs are registered.
- Values are stored unmodified; no arithmetic.

Test Plan:
1. Reset: rstn=0 for 2 cycles with random inputs -> all outputs 0, fstalled=0.
2. Basic capture:
   - Stimulus: RegWriteM1=1, writeRegM1=5, ResultM1=0x3F800000; RegWriteW4=1, writeRegW4=40, ResultW4=0x12345678; others RegWrite=0. Pulse Read_data_keep with StallE=1 for 3 cycles, then StallE=0.
   - Required: cycle+1 shows RegWriteKept1=1, writeRegKept1=5, ResultKept1=0x3F800000; RegWriteKept4=1, ResultKept4=0x12345678; fstalled=1.
   - Changing M/W inputs during HOLD must not alter outputs.
   - fstalled stays 1 one cycle after StallE falls, then all RegWriteKept=0.
3. Register zero: RegWriteW3=1, writeRegW3=0 at capture -> RegWriteKept3=0, fstalled=1.
4. Re-stall in RELEASE: assert Read_data_keep in the RELEASE cycle with new ResultM2=0xAAAA5555, writeRegM2=7, RegWriteM2=1.
   - Required: fstalled never drops; Kept2 becomes 7/0xAAAA5555; state returns to HOLD.
5. Reset mid-HOLD: rstn=0 during HOLD -> next cycle all outputs 0. A later StallE=0 causes no RELEASE artefacts.
6. Ignored strobe: second Read_data_keep during HOLD with different inputs -> Kept values unchanged.
